// File: rtl/tmds_decoder_if.sv
// Channel-side signals of one TMDS colour-channel decoder: raw words in, decoded symbol out.
// The slave modport belongs to the decoder; the master modport to whatever feeds it.
interface tmds_decoder_if;
    logic [9:0] tmds_in;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       locked_out;
    logic [3:0] offset_out;

    modport master (
        output tmds_in,
        input  data_out,
        input  ctrl_out,
        input  de_out,
        input  locked_out,
        input  offset_out
    );

    modport slave (
        input  tmds_in,
        output data_out,
        output ctrl_out,
        output de_out,
        output locked_out,
        output offset_out
    );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one colour channel: bit-slips over a 20-bit window until control
// tokens repeat, then decodes each aligned symbol to pixel data or control.
module tmds_decoder #(
    parameter int unsigned LOCK_COUNT     = 8,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOSS_TIMEOUT   = 2048
) (
    input  logic          clk_in,
    input  logic          rst_in,
    tmds_decoder_if.slave bus
);

    localparam int unsigned TimerMax = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT
                                                                      : LOSS_TIMEOUT;
    localparam int unsigned TimerW   = (TimerMax > 2) ? $clog2(TimerMax) : 1;
    localparam int unsigned RunW     = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;

    typedef enum logic {StSearch, StLocked} state_e;

    state_e              state_q, state_d;
    logic [9:0]          s0_q, s1_q;
    logic [3:0]          offset_q, offset_d;
    logic [RunW-1:0]     run_q, run_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [7:0]          data_q, data_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic                de_q, de_d;

    logic [19:0] window;
    logic [9:0]  aligned;
    logic        is_ctrl;
    logic [1:0]  token;
    logic [7:0]  d_prime;
    logic [7:0]  d;

    // s0 holds the newer word, so nonzero offsets pull their upper bits from it.
    assign window  = {s0_q, s1_q};
    assign aligned = window[offset_q +: 10];

    always_comb begin
        is_ctrl = 1'b1;
        token   = 2'b00;
        case (aligned)
            10'b1101010100: token = 2'b00;
            10'b0010101011: token = 2'b01;
            10'b0101010100: token = 2'b10;
            10'b1010101011: token = 2'b11;
            default:        is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        d_prime = aligned[9] ? ~aligned[7:0] : aligned[7:0];
        d       = '0;
        d[0]    = d_prime[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = aligned[8] ? (d_prime[i] ^ d_prime[i-1]) : ~(d_prime[i] ^ d_prime[i-1]);
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        timer_d  = timer_q;
        unique case (state_q)
            StSearch: begin
                timer_d = timer_q + 1'b1;
                run_d   = is_ctrl ? run_q + 1'b1 : '0;
                // Lock wins over a slip falling on the same cycle.
                if (is_ctrl && (run_q == RunW'(LOCK_COUNT - 1))) begin
                    state_d = StLocked;
                    timer_d = '0;
                    run_d   = '0;
                end else if (timer_q == TimerW'(SEARCH_TIMEOUT - 1)) begin
                    offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    timer_d  = '0;
                    run_d    = '0;
                end
            end
            StLocked: begin
                if (is_ctrl) begin
                    timer_d = '0;
                end else if (timer_q == TimerW'(LOSS_TIMEOUT - 1)) begin
                    state_d = StSearch;
                    timer_d = '0;
                    run_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    // Outputs are gated by the state before the edge, hence one cycle behind locked_out.
    always_comb begin
        data_d = '0;
        ctrl_d = '0;
        de_d   = 1'b0;
        if (state_q == StLocked) begin
            de_d   = ~is_ctrl;
            data_d = is_ctrl ? 8'h00 : d;
            ctrl_d = is_ctrl ? token : 2'b00;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= StSearch;
            s0_q     <= '0;
            s1_q     <= '0;
            offset_q <= '0;
            run_q    <= '0;
            timer_q  <= '0;
            data_q   <= '0;
            ctrl_q   <= '0;
            de_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s0_q     <= bus.tmds_in;
            s1_q     <= s0_q;
            offset_q <= offset_d;
            run_q    <= run_d;
            timer_q  <= timer_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            de_q     <= de_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.ctrl_out   = ctrl_q;
    assign bus.de_out     = de_q;
    assign bus.locked_out = (state_q == StLocked);
    assign bus.offset_out = offset_q;

endmodule
